mcpu_irq: RTL and testbench

Parametrised clock-enable and interrupt-request controller for 6502-class main CPUs. It replaces the single fixed coin latch and fixed-ratio enable with N synchronised interrupt channels. Each channel is edge-latched or level-following, maskable, and routed to IRQ or NMI. Channels resolve through a fixed-priority encoder. The block sits between board inputs (coin, vblank, sound/sub-CPU flags) and the CPU core's `clk`/`IRQ`/`NMI` pins.

---
 rtl/mcpu_irq.sv | 146 ++++++++++++++
 tb/tb_mcpu_irq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_irq.sv
// mcpu_irq: CPU clock-enable generator and N-channel IRQ/NMI controller
// for 6502-class cores; board requests are synchronised, latched, masked.
module mcpu_irq #(
  parameter int CHANNELS = 4,
  parameter int CEN_DIV  = 32,
  parameter logic [CHANNELS-1:0] EDGE_MASK = '1,
  parameter logic [CHANNELS-1:0] NMI_MASK  = '0,
  parameter logic [CHANNELS-1:0] MASK_INIT = '1,
  localparam int IDW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                cen_run,
  input  logic [CHANNELS-1:0] src,
  input  logic [CHANNELS-1:0] ack,
  input  logic                mask_we,
  input  logic [CHANNELS-1:0] mask_din,
  output logic                cpu_cen,
  output logic                irq_n,
  output logic                nmi_n,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] mask,
  output logic [IDW-1:0]      irq_id
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("mcpu_irq: CHANNELS must be 1..16");
  end
  if (CEN_DIV < 2 || CEN_DIV > 256) begin : g_bad_cen_div
    $error("mcpu_irq: CEN_DIV must be 2..256");
  end

  localparam logic [7:0] LAST = 8'(CEN_DIV - 1);

  logic [7:0]          r_cnt;
  logic                r_cen;
  logic [CHANNELS-1:0] r_s1;
  logic [CHANNELS-1:0] r_s2;
  logic [CHANNELS-1:0] r_s3;
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_mask;
  logic                r_irq_n;
  logic                r_nmi_n;
  logic [IDW-1:0]      r_id;

  logic [7:0]          w_cnt_nxt;
  logic                w_cen_nxt;
  logic [CHANNELS-1:0] w_edge;
  logic [CHANNELS-1:0] w_pend_nxt;
  logic [CHANNELS-1:0] w_active;
  logic [CHANNELS-1:0] w_irq_act;
  logic [CHANNELS-1:0] w_nmi_act;
  logic [IDW-1:0]      w_id_nxt;

  assign w_edge    = r_s2 & ~r_s3;
  assign w_active  = r_pend & r_mask;
  assign w_irq_act = w_active & ~NMI_MASK;
  assign w_nmi_act = w_active & NMI_MASK;

  // Enable counter: advance and wrap while running, freeze otherwise
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (cen_run) begin
      if (r_cnt == LAST) w_cnt_nxt = 8'd0;
      else               w_cnt_nxt = r_cnt + 8'd1;
    end
    w_cen_nxt = cen_run && (w_cnt_nxt == LAST);
  end

  // Pending next state: edge channels latch until ack, level channels follow
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < CHANNELS; i++) begin
      if (EDGE_MASK[i]) begin
        if (ack[i])         w_pend_nxt[i] = 1'b0;
        else if (w_edge[i]) w_pend_nxt[i] = 1'b1;
      end else begin
        w_pend_nxt[i] = r_s2[i];
      end
    end
  end

  // Fixed priority: lowest-index active IRQ-class channel wins
  always_comb begin
    w_id_nxt = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (w_irq_act[i]) w_id_nxt = IDW'(i);
    end
  end

  // Enable generator state
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 8'd0;
      r_cen <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_cen <= w_cen_nxt;
    end
  end

  // Two-flop synchroniser plus history flop for edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= src;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Pending and mask registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pend <= '0;
      r_mask <= MASK_INIT;
    end else begin
      r_pend <= w_pend_nxt;
      if (mask_we) r_mask <= mask_din;
    end
  end

  // Registered interrupt pins and vector id
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_n <= 1'b1;
      r_nmi_n <= 1'b1;
      r_id    <= '0;
    end else begin
      r_irq_n <= ~|w_irq_act;
      r_nmi_n <= ~|w_nmi_act;
      r_id    <= w_id_nxt;
    end
  end

  assign cpu_cen = r_cen;
  assign irq_n   = r_irq_n;
  assign nmi_n   = r_nmi_n;
  assign pending = r_pend;
  assign mask    = r_mask;
  assign irq_id  = r_id;

endmodule

// File: tb/tb_mcpu_irq.sv
// tb_mcpu_irq: directed vectors for mcpu_irq (default config and an
// NMI/level config), table-driven plus hand-written timing sequences.
module tb_mcpu_irq;

  logic       clk;
  logic       reset_n;
  logic       cen_run;
  logic [3:0] src;
  logic [3:0] ack;
  logic       mask_we;
  logic [3:0] mask_din;
  logic [3:0] src2;
  logic [3:0] ack2;

  logic       cen_a, irqn_a, nmin_a;
  logic [3:0] pend_a, mask_a;
  logic [1:0] id_a;
  logic       cen_b, irqn_b, nmin_b;
  logic [3:0] pend_b, mask_b;
  logic [1:0] id_b;

  int n_vec = 0;
  int n_err = 0;

  mcpu_irq dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .cen_run (cen_run),
    .src     (src),
    .ack     (ack),
    .mask_we (mask_we),
    .mask_din(mask_din),
    .cpu_cen (cen_a),
    .irq_n   (irqn_a),
    .nmi_n   (nmin_a),
    .pending (pend_a),
    .mask    (mask_a),
    .irq_id  (id_a)
  );

  mcpu_irq #(
    .EDGE_MASK(4'b1101),
    .NMI_MASK (4'b0001)
  ) dut_n (
    .clk_sys (clk),
    .reset_n (reset_n),
    .cen_run (cen_run),
    .src     (src2),
    .ack     (ack2),
    .mask_we (mask_we),
    .mask_din(mask_din),
    .cpu_cen (cen_b),
    .irq_n   (irqn_b),
    .nmi_n   (nmin_b),
    .pending (pend_b),
    .mask    (mask_b),
    .irq_id  (id_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] src;
    logic [3:0] ack;
    logic       we;
    logic [3:0] din;
    int         n;
    logic [3:0] pend;
    logic [3:0] msk;
    logic       irqn;
    logic [1:0] id;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int first, second, c, pulses;

    //           src    ack    we    din   n   pend   msk  irqn id
    tbl[0]  = '{4'h4, 4'h0, 1'b0, 4'h0, 3,  4'h4, 4'hF, 1'b1, 2'd0};
    tbl[1]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1,  4'h4, 4'hF, 1'b0, 2'd2};
    tbl[2]  = '{4'h0, 4'h0, 1'b0, 4'h0, 5,  4'h4, 4'hF, 1'b0, 2'd2};
    tbl[3]  = '{4'h0, 4'h4, 1'b0, 4'h0, 1,  4'h0, 4'hF, 1'b0, 2'd2};
    tbl[4]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1,  4'h0, 4'hF, 1'b1, 2'd0};
    tbl[5]  = '{4'h8, 4'h0, 1'b0, 4'h0, 10, 4'h8, 4'hF, 1'b0, 2'd3};
    tbl[6]  = '{4'hA, 4'h0, 1'b0, 4'h0, 3,  4'hA, 4'hF, 1'b0, 2'd3};
    tbl[7]  = '{4'hA, 4'h0, 1'b0, 4'h0, 1,  4'hA, 4'hF, 1'b0, 2'd1};
    tbl[8]  = '{4'hA, 4'h2, 1'b0, 4'h0, 1,  4'h8, 4'hF, 1'b0, 2'd1};
    tbl[9]  = '{4'hA, 4'h0, 1'b0, 4'h0, 1,  4'h8, 4'hF, 1'b0, 2'd3};
    tbl[10] = '{4'hA, 4'h8, 1'b0, 4'h0, 1,  4'h0, 4'hF, 1'b0, 2'd3};
    tbl[11] = '{4'hA, 4'h0, 1'b0, 4'h0, 1,  4'h0, 4'hF, 1'b1, 2'd0};
    tbl[12] = '{4'h0, 4'h0, 1'b1, 4'hE, 1,  4'h0, 4'hE, 1'b1, 2'd0};
    tbl[13] = '{4'h1, 4'h0, 1'b0, 4'h0, 3,  4'h1, 4'hE, 1'b1, 2'd0};
    tbl[14] = '{4'h1, 4'h0, 1'b0, 4'h0, 5,  4'h1, 4'hE, 1'b1, 2'd0};
    tbl[15] = '{4'h1, 4'h0, 1'b1, 4'hF, 1,  4'h1, 4'hF, 1'b1, 2'd0};
    tbl[16] = '{4'h1, 4'h0, 1'b0, 4'h0, 1,  4'h1, 4'hF, 1'b0, 2'd0};
    tbl[17] = '{4'h0, 4'h1, 1'b0, 4'h0, 1,  4'h0, 4'hF, 1'b0, 2'd0};
    tbl[18] = '{4'h0, 4'h0, 1'b0, 4'h0, 3,  4'h0, 4'hF, 1'b1, 2'd0};
    tbl[19] = '{4'h1, 4'h0, 1'b0, 4'h0, 2,  4'h0, 4'hF, 1'b1, 2'd0};
    tbl[20] = '{4'h1, 4'h1, 1'b0, 4'h0, 1,  4'h0, 4'hF, 1'b1, 2'd0};
    tbl[21] = '{4'h1, 4'h0, 1'b0, 4'h0, 3,  4'h0, 4'hF, 1'b1, 2'd0};

    reset_n  = 1'b0;
    cen_run  = 1'b1;
    src      = 4'hF;
    ack      = 4'h0;
    mask_we  = 1'b0;
    mask_din = 4'h0;
    src2     = 4'h0;
    ack2     = 4'h0;

    // reset defaults with requests held high
    step(3);
    chk("rst_irq_n", 32'(irqn_a), 32'd1);
    chk("rst_nmi_n", 32'(nmin_a), 32'd1);
    chk("rst_mask", 32'(mask_a), 32'hF);
    chk("rst_cen", 32'(cen_a), 32'd0);
    chk("rst_id", 32'(id_a), 32'd0);
    chk("rst_pend", 32'(pend_a), 32'd0);

    src = 4'h0;
    step(2);
    reset_n = 1'b1;

    // enable cadence after release
    first  = 0;
    second = 0;
    for (int k = 1; k <= 70; k++) begin
      step(1);
      if (k == 1) begin
        chk("rel_irq_n", 32'(irqn_a), 32'd1);
        chk("rel_cen", 32'(cen_a), 32'd0);
      end
      if (cen_a) begin
        if (first == 0)       first  = k;
        else if (second == 0) second = k;
      end
    end
    chk("cen_first", 32'(first), 32'd31);
    chk("cen_second", 32'(second), 32'd63);

    // edge latch, ack, priority, mask, ack-vs-edge
    for (int k = 0; k < NV; k++) begin
      src      = tbl[k].src;
      ack      = tbl[k].ack;
      mask_we  = tbl[k].we;
      mask_din = tbl[k].din;
      step(tbl[k].n);
      chk($sformatf("v%0d_pend", k), 32'(pend_a), 32'(tbl[k].pend));
      chk($sformatf("v%0d_mask", k), 32'(mask_a), 32'(tbl[k].msk));
      chk($sformatf("v%0d_irq_n", k), 32'(irqn_a), 32'(tbl[k].irqn));
      chk($sformatf("v%0d_id", k), 32'(id_a), 32'(tbl[k].id));
    end
    src      = 4'h0;
    ack      = 4'h0;
    mask_we  = 1'b0;

    // NMI routing and level channel on the second instance
    src2 = 4'h1;
    step(3);
    chk("nmi_early", 32'(nmin_b), 32'd1);
    chk("nmi_pend", 32'(pend_b), 32'h1);
    step(1);
    chk("nmi_low", 32'(nmin_b), 32'd0);
    chk("nmi_irq_n", 32'(irqn_b), 32'd1);
    chk("nmi_id", 32'(id_b), 32'd0);
    src2 = 4'h3;
    step(4);
    chk("lvl_irq_n", 32'(irqn_b), 32'd0);
    chk("lvl_id", 32'(id_b), 32'd1);
    ack2 = 4'h2;
    step(1);
    ack2 = 4'h0;
    step(1);
    chk("lvl_ack_pend", 32'(pend_b), 32'h3);
    chk("lvl_ack_irq", 32'(irqn_b), 32'd0);
    src2 = 4'h1;
    step(3);
    chk("lvl_drop3", 32'(irqn_b), 32'd0);
    chk("lvl_drop_pend", 32'(pend_b), 32'h1);
    step(1);
    chk("lvl_drop4", 32'(irqn_b), 32'd1);
    ack2 = 4'h1;
    step(1);
    ack2 = 4'h0;
    step(1);
    chk("nmi_ack", 32'(nmin_b), 32'd1);
    chk("nmi_ack_pend", 32'(pend_b), 32'h0);

    // mid-operation async reset at cnt = 20 with all channels pending
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    src = 4'hF;
    step(5);
    mask_we  = 1'b1;
    mask_din = 4'h7;
    step(1);
    mask_we = 1'b0;
    step(14);
    chk("pre_pend", 32'(pend_a), 32'hF);
    chk("pre_mask", 32'(mask_a), 32'h7);
    chk("pre_irq_n", 32'(irqn_a), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_irq_n", 32'(irqn_a), 32'd1);
    chk("ar_nmi_n", 32'(nmin_a), 32'd1);
    chk("ar_pend", 32'(pend_a), 32'h0);
    chk("ar_mask", 32'(mask_a), 32'hF);
    chk("ar_id", 32'(id_a), 32'd0);
    chk("ar_cen", 32'(cen_a), 32'd0);
    src  = 4'h0;
    src2 = 4'h0;

    // cen_run pause at cnt = 10 for 50 cycles
    step(1);
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (cen_a) pulses++;
    end
    cen_run = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (cen_a) pulses++;
    end
    chk("pause_pulses", 32'(pulses), 32'd0);
    cen_run = 1'b1;
    c = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1);
      if (cen_a && c == 0) c = k;
    end
    chk("resume_cen", 32'(c), 32'd21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
